// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, centred sampling, one-cycle byte strobe.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames with parity checking.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rx_m;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        w_sample;
  logic        w_shift_en;
  logic        w_valid;
  logic        w_ferr;

`ifdef UART_RX_PARITY_EN
  localparam logic P_ODD = 1'(PARITY_ODD);
  logic r_par_err;
  logic w_perr;
`else
  logic w_unused_odd;
  assign w_unused_odd = PARITY_ODD[0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= i_rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_sample   = 1'b0;
    w_shift_en = 1'b0;
    w_valid    = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr     = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (r_rx_d && !r_rx_s) w_next = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_sample = 1'b1;
          // line back high at mid start bit: treat as glitch
          w_next   = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_sample   = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_sample = 1'b1;
          w_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_sample = 1'b1;
          if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (r_par_err) w_perr = 1'b1;
            else           w_valid = 1'b1;
`else
            w_valid = 1'b1;
`endif
            w_next = S_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_next != r_state || w_sample) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 16'd1;
      if (w_next != r_state) r_bit <= '0;
      else if (w_shift_en)   r_bit <= r_bit + 3'd1;
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_err    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_par_err <= 1'b0;
      else if (r_state == S_PARITY && w_sample)
        r_par_err <= r_rx_s != ((^r_shift) ^ P_ODD);
      o_parity_err <= w_perr;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= w_valid;
      o_frame_err <= w_ferr;
      if (w_valid) o_data <= r_shift;
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized UART frames against a frame-level model,
// checked by a scoreboard monitor on the strobe outputs.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CPB  = 16;
  localparam int  PODD = 0;
  localparam real TCLK = 10.0;
  localparam real NOM  = 160.0;
  localparam real FAST = 155.2;
  localparam real SLOW = 164.8;
`ifdef UART_RX_PARITY_EN
  localparam int  LAT  = 172;
`else
  localparam int  LAT  = 156;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_last = 8'h00;
  realtime    t_valid = 0;
  realtime    t_fall = 0;

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // frame-level model: stop low beats parity, bad frames keep old data
  task automatic expect_frame(input logic [7:0] d, input logic pb,
                              input logic stop);
    ev_t e;
    if (!stop) begin
      e.kind = 1;
      e.data = model_last;
`ifdef UART_RX_PARITY_EN
    end else if (pb != par_of(d)) begin
      e.kind = 2;
      e.data = model_last;
`endif
    end else begin
      e.kind = 0;
      e.data = d;
      model_last = d;
    end
    if (pb === 1'bx) e.kind = -1;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic pb, input logic stop,
                      input real bns, input bit chk_busy);
    expect_frame(d, pb, stop);
    t_fall = $realtime;
    rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (chk_busy) begin
        #(bns / 2);
        check("busy_in_frame", int'(o_busy), 1);
        #(bns / 2);
      end else begin
        #(bns);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = pb;
    #(bns);
`endif
    rx = stop;
    #(bns);
  endtask

  always @(negedge clk) begin
    int  k;
    ev_t e;
    if (rst_n && (o_valid || o_frame_err || o_parity_err)) begin
      check("strobe_onehot",
            $countones({o_valid, o_frame_err, o_parity_err}), 1);
      k = o_valid ? 0 : (o_frame_err ? 1 : 2);
      if (o_valid) t_valid = $realtime;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: kind %0d data %0h, none expected",
                 k, o_data);
      end else begin
        e = exp_q.pop_front();
        if (k != e.kind || o_data != e.data) begin
          errors++;
          $display("FAIL event: kind %0d data %0h required kind %0d data %0h",
                   k, o_data, e.kind, e.data);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [7:0] d;
    logic       stop;
    logic       pb;
    real        bns;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", int'(o_data), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_perr", int'(o_parity_err), 0);
    check("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hA5, par_of(8'hA5), 1'b1, NOM, 1'b1);
    lat = int'((t_valid - t_fall) / TCLK);
    checks++;
    if (lat < LAT - 2 || lat > LAT + 2) begin
      errors++;
      $display("FAIL latency_a5: got %0d cycles required %0d+-2", lat, LAT);
    end
    #(NOM);

    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", int'(o_busy), 0);
    @(negedge clk);
    send(8'h3C, par_of(8'h3C), 1'b1, NOM, 1'b0);
    #(NOM);

    @(negedge clk);
    send(8'h55, par_of(8'h55), 1'b0, NOM, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy", int'(o_busy), 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_release", int'(o_busy), 0);
    send(8'h81, par_of(8'h81), 1'b1, NOM, 1'b0);
    #(NOM);

    @(negedge clk);
    send(8'h00, par_of(8'h00), 1'b1, SLOW, 1'b0);
    send(8'hFF, par_of(8'hFF), 1'b1, SLOW, 1'b0);
    send(8'h7E, par_of(8'h7E), 1'b1, FAST, 1'b0);
    #(NOM * 2);

`ifdef UART_RX_PARITY_EN
    @(negedge clk);
    send(8'h0F, 1'b0, 1'b1, NOM, 1'b0);
    #(NOM);
    send(8'h0F, 1'b1, 1'b1, NOM, 1'b0);
    #(NOM);
`endif

    @(negedge clk);
    d = 8'hC3;
    rx = 1'b0;
    #(NOM);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      #(NOM);
    end
    rx = d[3];
    #(NOM / 2);
    rst_n = 1'b0;
    #1;
    model_last = 8'h00;
    check("midrst_data", int'(o_data), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_ferr", int'(o_frame_err), 0);
    check("midrst_perr", int'(o_parity_err), 0);
    check("midrst_busy", int'(o_busy), 0);
    rx = 1'b1;
    #(NOM * 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h99, par_of(8'h99), 1'b1, NOM, 1'b0);
    #(NOM);

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pb   = par_of(d) ^ ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0:       bns = FAST;
        1:       bns = SLOW;
        default: bns = NOM;
      endcase
      @(negedge clk);
      send(d, pb, stop, bns, 1'b0);
      if (!stop) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        rx = 1'b1;
        #(NOM);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    repeat (100) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
